// File: rtl/load_pkg.sv
// Shared encodings and state type for the load data-fetch path.
package load_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Wide enough for the largest supported memory latency (7).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  // A request is legal when its size is defined and it is naturally aligned.
  function automatic logic req_legal(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdr_aligner.sv
// Moves the addressed byte lane of a little-endian word down to bit 0, zero-filled.
module mdr_aligner
  import load_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  assign data_o = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/mem_data_fetch.sv
// Single-outstanding load fetcher: checks alignment, waits MEM_LAT cycles on
// memory, then presents the lane-aligned word and its size to the load-width stage.
module mem_data_fetch
  import load_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [1:0]  size_out,
  output logic        misalign
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_addr_q;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic [31:0]        data_q;
  logic [1:0]         size_out_q;
  logic [31:0]        aligned;
  logic               legal;
  logic               accept;
  logic               capture;

  assign legal  = req_legal(size, addr[1:0]);
  assign accept = (state_q == IDLE) && start && legal;
  // cnt_q <= 1 rather than == 1 so an out-of-range latency cannot wedge WAIT.
  assign capture = (state_q == WAIT) && (cnt_q <= CNT_W'(1));

  mdr_aligner u_align (
    .rdata_i (mem_rdata),
    .off_i   (off_q),
    .data_o  (aligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(MEM_LAT);
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (capture) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch and capture registers; an ERR request touches none of them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      off_q      <= '0;
      size_q     <= '0;
      data_q     <= '0;
      size_out_q <= '0;
    end else begin
      if (accept) begin
        mem_addr_q <= {addr[31:2], 2'b00};
        off_q      <= addr[1:0];
        size_q     <= size;
      end
      if (capture) begin
        data_q     <= aligned;
        size_out_q <= size_q;
      end
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign mem_rd   = (state_q == WAIT);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign misalign = (state_q == ERR);
  assign mem_addr = mem_addr_q;
  assign data_out = data_q;
  assign size_out = size_out_q;

endmodule

// File: tb/tb_mem_data_fetch.sv
// Bench for mem_data_fetch: two instances (latency 1 and 3) share stimulus and
// are each checked every cycle against a timestamp-based reference model.
module tb_mem_data_fetch;

  localparam int LAT[2] = '{1, 3};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] mem_rdata = '0;

  logic [1:0][31:0] mem_addr_w, data_w;
  logic [1:0][1:0]  szo_w;
  logic [1:0]       rd_w, busy_w, done_w, mis_w;

  mem_data_fetch #(.MEM_LAT(1)) u_l1 (
    .clock(clock), .reset_n(reset_n), .start(start), .addr(addr), .size(size),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr_w[0]), .mem_rd(rd_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .data_out(data_w[0]),
    .size_out(szo_w[0]), .misalign(mis_w[0])
  );

  mem_data_fetch #(.MEM_LAT(3)) u_l3 (
    .clock(clock), .reset_n(reset_n), .start(start), .addr(addr), .size(size),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr_w[1]), .mem_rd(rd_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .data_out(data_w[1]),
    .size_out(szo_w[1]), .misalign(mis_w[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: a transaction is an acceptance edge plus a kind (0 none, 1 load, 2 error).
  int          edge_n = 0;
  int          acc_e[2];
  int          kind[2];
  logic [1:0]  acc_off[2], acc_sz[2];
  logic [31:0] e_addr[2], e_data[2];
  logic [1:0]  e_size[2];
  int          n_done[2], n_mis[2], n_rd[2];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [31:0] rd;
    logic [31:0] exp_data;
    logic [1:0]  exp_sz;
    bit          err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat%0d edge=%0d actual=%h required=%h", nm, LAT[d], edge_n, act, exp);
    end
  endtask

  function automatic bit legal_req(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd0) || (s == 2'd1 && !a[0]) || (s == 2'd2 && a[1:0] == 2'd0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      kind[d] = 0; acc_e[d] = 0; acc_off[d] = '0; acc_sz[d] = '0;
      e_addr[d] = '0; e_data[d] = '0; e_size[d] = '0;
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      n_done[d] = 0; n_mis[d] = 0; n_rd[d] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, ".mem_addr"}, d, mem_addr_w[d], 32'h0);
      chk({tag, ".mem_rd"},   d, 32'(rd_w[d]),   32'h0);
      chk({tag, ".busy"},     d, 32'(busy_w[d]), 32'h0);
      chk({tag, ".done"},     d, 32'(done_w[d]), 32'h0);
      chk({tag, ".data_out"}, d, data_w[d],      32'h0);
      chk({tag, ".size_out"}, d, 32'(szo_w[d]),  32'h0);
      chk({tag, ".misalign"}, d, 32'(mis_w[d]),  32'h0);
    end
  endtask

  // Called at a falling edge: drive inputs, advance one clock, check the new cycle.
  task automatic step(input logic st, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd);
    bit idle;
    int k;
    bit x_rd, x_done, x_mis;
    start = st; addr = a; size = sz; mem_rdata = rd;
    for (int d = 0; d < 2; d++) begin
      if (kind[d] == 1 && edge_n == acc_e[d] + LAT[d]) begin
        e_data[d] = rd >> (8 * int'(acc_off[d]));
        e_size[d] = acc_sz[d];
      end
      idle = (kind[d] == 0) ||
             (kind[d] == 1 && edge_n >= acc_e[d] + LAT[d] + 2) ||
             (kind[d] == 2 && edge_n >= acc_e[d] + 2);
      if (idle && st) begin
        acc_e[d] = edge_n;
        if (legal_req(a, sz)) begin
          kind[d] = 1; acc_off[d] = a[1:0]; acc_sz[d] = sz;
          e_addr[d] = {a[31:2], 2'b00};
        end else begin
          kind[d] = 2;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      k = edge_n - acc_e[d];
      x_rd   = (kind[d] == 1) && (k >= 0) && (k < LAT[d]);
      x_done = (kind[d] == 1) && (k == LAT[d]);
      x_mis  = (kind[d] == 2) && (k == 0);
      chk("mem_rd",   d, 32'(rd_w[d]),   32'(x_rd));
      chk("done",     d, 32'(done_w[d]), 32'(x_done));
      chk("misalign", d, 32'(mis_w[d]),  32'(x_mis));
      chk("busy",     d, 32'(busy_w[d]), 32'(x_rd | x_done | x_mis));
      chk("mem_addr", d, mem_addr_w[d],  e_addr[d]);
      chk("data_out", d, data_w[d],      e_data[d]);
      chk("size_out", d, 32'(szo_w[d]),  32'(e_size[d]));
      n_done[d] += int'(done_w[d]);
      n_mis[d]  += int'(mis_w[d]);
      n_rd[d]   += int'(rd_w[d]);
    end
    edge_n++;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b0};
    tbl[1] = '{32'h0000_0103, 2'b00, 32'h1122_3344, 32'h0000_0011, 2'b00, 1'b0};
    tbl[2] = '{32'h0000_0102, 2'b01, 32'h1122_3344, 32'h0000_1122, 2'b01, 1'b0};
    tbl[3] = '{32'h0000_0101, 2'b01, 32'h5555_AAAA, 32'h0000_1122, 2'b01, 1'b1};
    tbl[4] = '{32'h0000_0000, 2'b11, 32'h5555_AAAA, 32'h0000_1122, 2'b01, 1'b1};
    tbl[5] = '{32'h0000_0101, 2'b00, 32'hA1B2_C3D4, 32'h00A1_B2C3, 2'b00, 1'b0};
    tbl[6] = '{32'h0000_0100, 2'b01, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 2'b01, 1'b0};
    tbl[7] = '{32'h0000_0102, 2'b10, 32'h0F0F_0F0F, 32'hA1B2_C3D4, 2'b01, 1'b1};

    model_reset();
    clr();
    #1;
    chk_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table: one request, then quiet cycles with read data held.
    for (int i = 0; i < 8; i++) begin
      clr();
      step(1'b1, tbl[i].addr, tbl[i].sz, tbl[i].rd);
      for (int j = 0; j < 6; j++) step(1'b0, 32'h0, 2'b00, tbl[i].rd);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d.data_out", i), d, data_w[d], tbl[i].exp_data);
        chk($sformatf("tbl%0d.size_out", i), d, 32'(szo_w[d]), 32'(tbl[i].exp_sz));
        chk($sformatf("tbl%0d.misalign_cnt", i), d, 32'(n_mis[d]), 32'(tbl[i].err));
        chk($sformatf("tbl%0d.done_cnt", i), d, 32'(n_done[d]), 32'(!tbl[i].err));
        chk($sformatf("tbl%0d.rd_cycles", i), d, 32'(n_rd[d]), tbl[i].err ? 32'd0 : 32'(LAT[d]));
      end
    end

    // Start held high through the latency-3 access: one access, one done.
    clr();
    step(1'b1, 32'h0000_0200, 2'b10, 32'hCAFE_F00D);
    for (int j = 0; j < 3; j++) step(1'b1, 32'h0000_0204, 2'b10, 32'hCAFE_F00D);
    for (int j = 0; j < 4; j++) step(1'b0, 32'h0, 2'b00, 32'h0);
    chk("restart.done_cnt", 1, 32'(n_done[1]), 32'd1);
    chk("restart.rd_cycles", 1, 32'(n_rd[1]), 32'd3);
    chk("restart.mem_addr", 1, mem_addr_w[1], 32'h0000_0200);
    chk("restart.data_out", 1, data_w[1], 32'hCAFE_F00D);
    for (int j = 0; j < 4; j++) step(1'b0, 32'h0, 2'b00, 32'h0);

    // Reset in the middle of WAIT.
    step(1'b1, 32'h0000_0300, 2'b10, 32'h1234_5678);
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_zero("midwait_reset");
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    reset_n = 1'b1;
    clr();
    for (int j = 0; j < 6; j++) step(1'b0, 32'h0, 2'b00, 32'h1234_5678);
    for (int d = 0; d < 2; d++) chk("post_reset.done_cnt", d, 32'(n_done[d]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
    end
    for (int j = 0; j < 6; j++) step(1'b0, 32'h0, 2'b00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
